decoder_display_7_segment: RTL and testbench

Hex-digit to 7-segment display decoder with registered outputs. Converts a 4-bit nibble (0–F) into the segment pattern for one common-cathode or common-anode digit, plus decimal point. Sits between a numeric datapath (counters, BCD converters) and the board's LED digit pins, one instance per digit.

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/seg7_glyph_rom.sv | 13 +
 rtl/decoder_display_7_segment.sv | 46 ++++
 tb/tb_decoder_display_7_segment.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment bit indices, hex glyph table and dark pattern
package seg7_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high gfedcba; b and d are lowercase so they differ from 8 and 0
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [7:0] SEG_DARK = 8'h00;

endpackage

// File: rtl/seg7_glyph_rom.sv
// rtl/seg7_glyph_rom.sv - combinational nibble to active-high gfedcba glyph
module seg7_glyph_rom
    import seg7_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] glyph_o
);

    always_comb begin
        glyph_o = GLYPH_TABLE[digit_i];
    end

endmodule

// File: rtl/decoder_display_7_segment.sv
// rtl/decoder_display_7_segment.sv - registered hex to 7-segment decoder with dp, blank, polarity
module decoder_display_7_segment
    import seg7_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    output logic [7:0] o,
    input  logic [3:0] i,
    input  logic       clk,
    input  logic       reset,
    input  logic       dp,
    input  logic       blank
);

    logic [6:0] glyph;
    logic [7:0] base;
    logic [7:0] o_d;
    logic [7:0] o_q;

    seg7_glyph_rom u_glyph_rom (
        .digit_i (i),
        .glyph_o (glyph)
    );

    // Blank also kills dp; polarity is applied last so it covers all 8 bits
    always_comb begin
        base         = SEG_DARK;
        o_d          = SEG_DARK;
        if (!blank) begin
            base[SEG_G:SEG_A] = glyph;
            base[SEG_DP]      = dp;
        end
        o_d = ACTIVE_LOW ? ~base : base;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_q <= ACTIVE_LOW ? ~SEG_DARK : SEG_DARK;
        end else begin
            o_q <= o_d;
        end
    end

    assign o = o_q;

endmodule

// File: tb/tb_decoder_display_7_segment.sv
// tb/tb_decoder_display_7_segment.sv - self-checking bench for both display polarities
module tb_decoder_display_7_segment;

    logic       clk;
    logic       reset;
    logic [3:0] i;
    logic       dp;
    logic       blank;
    logic [7:0] o_cc;
    logic [7:0] o_ca;

    int compared;
    int mismatched;

    decoder_display_7_segment #(.ACTIVE_LOW(1'b0)) dut_cc (
        .o     (o_cc),
        .i     (i),
        .clk   (clk),
        .reset (reset),
        .dp    (dp),
        .blank (blank)
    );

    decoder_display_7_segment #(.ACTIVE_LOW(1'b1)) dut_ca (
        .o     (o_ca),
        .i     (i),
        .clk   (clk),
        .reset (reset),
        .dp    (dp),
        .blank (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Segment shapes of the hex digits, a in bit 0 up to g in bit 6
    function automatic logic [7:0] model(input logic [3:0] d, input logic p, input logic b,
                                         input logic r, input logic al);
        logic [6:0] shapes [16];
        logic [7:0] v;
        shapes = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        if (r || b) v = 8'h00;
        else        v = {p, shapes[d]};
        return al ? (8'hFF ^ v) : v;
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drive away from the active edge, then sample both outputs just after it
    task automatic step(input logic [3:0] d, input logic p, input logic b, input logic r,
                        input string tag);
        @(negedge clk);
        i = d; dp = p; blank = b; reset = r;
        @(posedge clk);
        #1;
        check({tag, "_cc"}, o_cc, model(d, p, b, r, 1'b0));
        check({tag, "_ca"}, o_ca, model(d, p, b, r, 1'b1));
    endtask

    initial begin
        logic [3:0] rd;
        logic       rp, rb, rr;
        logic [7:0] held;
        compared   = 0;
        mismatched = 0;
        reset = 1'b1; i = 4'd8; dp = 1'b0; blank = 1'b0;

        step(4'd8, 1'b0, 1'b0, 1'b1, "reset0");
        step(4'd8, 1'b0, 1'b0, 1'b1, "reset1");
        check("reset_dark_cc", o_cc, 8'h00);
        check("reset_dark_ca", o_ca, 8'hFF);
        step(4'd8, 1'b0, 1'b0, 1'b0, "release");
        check("release_8", o_cc, 8'h7F);

        for (int k = 0; k < 16; k++) begin
            step(k[3:0], 1'b0, 1'b0, 1'b0, "sweep");
            check("sweep_dp_dark", {7'b0, o_cc[7]}, 8'h00);
            if (k == 0)  check("sweep_0", o_cc, 8'h3F);
            if (k == 4)  check("sweep_4", o_cc, 8'h66);
            if (k == 10) check("sweep_A", o_cc, 8'h77);
            if (k == 15) check("sweep_F", o_cc, 8'h71);
        end

        step(4'd5, 1'b1, 1'b0, 1'b0, "dp_on");
        check("dp_on_5", o_cc, 8'hED);
        step(4'd5, 1'b0, 1'b0, 1'b0, "dp_off");
        check("dp_off_5", o_cc, 8'h6D);

        step(4'd3, 1'b1, 1'b1, 1'b0, "blank_on");
        check("blank_wins", o_cc, 8'h00);
        step(4'd3, 1'b1, 1'b0, 1'b0, "blank_off");
        check("blank_off_3dp", o_cc, 8'hCF);

        step(4'd0, 1'b0, 1'b0, 1'b0, "al_zero");
        check("al_0", o_ca, 8'hC0);
        step(4'd1, 1'b1, 1'b0, 1'b0, "al_one_dp");
        check("al_1dp", o_ca, 8'h79);

        step(4'd9, 1'b1, 1'b0, 1'b1, "mid_reset");
        check("mid_reset_dark", o_cc, 8'h00);

        // Glitchy input inside one cycle: only the value at the edge counts
        @(negedge clk);
        reset = 1'b0; dp = 1'b0; blank = 1'b0; i = 4'd2;
        #1 i = 4'd7;
        #1 i = 4'd2;
        @(posedge clk);
        #1;
        check("sample_edge", o_cc, 8'h5B);
        held = o_cc;
        i = 4'd8; dp = 1'b1;
        #2;
        check("hold_between_edges", o_cc, held);
        i = 4'd2; dp = 1'b0;

        for (int k = 0; k < 200; k++) begin
            rd = 4'($urandom_range(0, 15));
            rp = 1'($urandom_range(0, 1));
            rb = ($urandom_range(0, 5) == 0);
            rr = ($urandom_range(0, 15) == 0);
            step(rd, rp, rb, rr, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        mismatched++;
        $display("FAIL timeout: observed no finish expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "timeout");
    end

endmodule
